// File: rtl/jtbubl_colmix_pkg.sv
// rtl/jtbubl_colmix_pkg.sv - shared types and constants for the colour mixer
//
// Contents:
//   seq_state_t   : palette sequencer states (IDLE=0, RD_LO=1, RD_HI=2, CAPT=3)
//   PAL_LO/PAL_HI : byte lane select appended to the colour index
//   BLANK_COL_DEF : RGB driven while the beam is blanked

package jtbubl_colmix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    CAPT  = 2'd3
  } seq_state_t;

  localparam logic PAL_LO = 1'b0;  // {R,G} byte
  localparam logic PAL_HI = 1'b1;  // {B,x} byte

  localparam logic [11:0] BLANK_COL_DEF = 12'h000;

endpackage

// File: rtl/jtbubl_colmix_seq.sv
// rtl/jtbubl_colmix_seq.sv - palette lookup sequencer: fetches both bytes of one entry per pixel
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   pxl_cen  : pixel enable; latches a new index and (re)starts the fetch
//   idx_in   : colour index to look up
//   q1       : video port read data from the palette RAM
//   vaddr    : video port byte address {idx, lane}
//   col      : last fully assembled colour {R,G,B}

module jtbubl_colmix_seq
  import jtbubl_colmix_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic [7:0]  idx_in,
  input  logic [7:0]  q1,
  output logic [8:0]  vaddr,
  output logic [11:0] col
);

  seq_state_t st, st_nxt;
  logic [7:0] idx;
  logic [7:0] lo;   // lo byte fetched for the entry in flight
  logic [7:0] rg;   // committed {R,G}
  logic [3:0] b;    // committed B

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    vaddr  = {idx, PAL_LO};
    unique case (st)
      IDLE:  st_nxt = IDLE;
      RD_LO: begin
        vaddr  = {idx, PAL_LO};
        st_nxt = RD_HI;
      end
      RD_HI: begin
        vaddr  = {idx, PAL_HI};
        st_nxt = CAPT;
      end
      CAPT:  st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
    // A new pixel always wins, even mid-fetch.
    if (pxl_cen) st_nxt = RD_LO;
  end

  // rg and b only change together in CAPT, so an aborted fetch leaves the
  // previous colour intact for the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 8'd0;
      lo  <= 8'd0;
      rg  <= 8'd0;
      b   <= 4'd0;
    end else if (pxl_cen) begin
      idx <= idx_in;
    end else begin
      if (st == RD_HI) lo <= q1;
      if (st == CAPT) begin
        rg <= lo;
        b  <= q1[7:4];
      end
    end
  end

  assign col = {rg, b};

endmodule

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - dual-port RAM, CPU read/write port plus read-only video port
//
// Ports:
//   clk          : clock
//   data0/addr0  : port 0 write data / address
//   we0          : port 0 write enable
//   q0           : port 0 read data, combinational on addr0 (the user registers it)
//   addr1        : port 1 address
//   q1           : port 1 read data, registered (1 cycle latency)
// A port 1 read that coincides with a port 0 write to the same address
// returns the value held before the write.

module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 9
) (
  input  logic          clk,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  // Read and write share one process so the read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    q1 <= mem[addr1];
  end

  assign q0 = mem[addr0];

endmodule

// File: rtl/jtbubl_colmix.sv
// rtl/jtbubl_colmix.sv - final video stage: palette lookup, blanking and blank delay
//
// Optional feature macro: JTBUBL_GFX_DEBUG_EN
//   adds gfx_en (0 forces palette entry 255) and pal_rd_idx (current index).
//
// Ports:
//   clk, rst          : 48 MHz clock, asynchronous active-high reset
//   pxl2_cen, pxl_cen : 12 MHz / 6 MHz enables (pxl2_cen not used here)
//   LHBL, LVBL        : blanking inputs, active low
//   col_addr          : colour index from the line buffer
//   pal_cs, cpu_rnw, cpu_addr, cpu_dout : CPU palette access
//   pal_dout          : CPU read data, registered
//   red, green, blue  : pixel colour, 4 bits each
//   LHBL_dly, LVBL_dly: blanking aligned to the colour outputs

module jtbubl_colmix
  import jtbubl_colmix_pkg::*;
#(
  parameter int          PAL_AW    = 9,
  parameter logic [11:0] BLANK_COL = BLANK_COL_DEF
) (
`ifdef JTBUBL_GFX_DEBUG_EN
  input  logic              gfx_en,
  output logic [7:0]        pal_rd_idx,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl2_cen,
  input  logic              pxl_cen,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic [7:0]        col_addr,
  input  logic              pal_cs,
  input  logic              cpu_rnw,
  input  logic [PAL_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        pal_dout,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              LHBL_dly,
  output logic              LVBL_dly
);

  logic [7:0]        idx_src;
  logic [8:0]        vaddr;
  logic [11:0]       col;
  logic [7:0]        q0, q1;
  logic              pal_we;
  logic              LHBL_d1, LVBL_d1;
  logic              unused_pxl2;

  assign unused_pxl2 = pxl2_cen;
  assign pal_we      = pal_cs & ~cpu_rnw;

`ifdef JTBUBL_GFX_DEBUG_EN
  assign idx_src    = gfx_en ? col_addr : 8'hFF;
  assign pal_rd_idx = vaddr[8:1];
`else
  assign idx_src    = col_addr;
`endif

  jtframe_dual_ram #(.dw(8), .aw(PAL_AW)) u_pal (
    .clk   (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_addr),
    .we0   (pal_we),
    .q0    (q0),
    .addr1 (vaddr),
    .q1    (q1)
  );

  jtbubl_colmix_seq u_seq (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .idx_in  (idx_src),
    .q1      (q1),
    .vaddr   (vaddr),
    .col     (col)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pal_dout <= 8'd0;
    else     pal_dout <= q0;
  end

  // col still holds the previous pixel's colour at this edge, which gives
  // the one-pixel latency; blanking is delayed by the same single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LHBL_d1  <= 1'b0;
      LVBL_d1  <= 1'b0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
      red      <= 4'd0;
      green    <= 4'd0;
      blue     <= 4'd0;
    end else if (pxl_cen) begin
      LHBL_d1  <= LHBL;
      LVBL_d1  <= LVBL;
      LHBL_dly <= LHBL_d1;
      LVBL_dly <= LVBL_d1;
      {red, green, blue} <= (LHBL_d1 & LVBL_d1) ? col : BLANK_COL;
    end
  end

endmodule

// File: tb/tb_jtbubl_colmix.sv
// tb/tb_jtbubl_colmix.sv - directed table-driven bench for jtbubl_colmix

module tb_jtbubl_colmix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl2_cen = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b0;
  logic       LVBL = 1'b0;
  logic [7:0] col_addr = 8'd0;
  logic       pal_cs = 1'b0;
  logic       cpu_rnw = 1'b1;
  logic [8:0] cpu_addr = 9'd0;
  logic [7:0] cpu_dout = 8'd0;
  logic [7:0] pal_dout;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;
`ifdef JTBUBL_GFX_DEBUG_EN
  logic       gfx_en = 1'b1;
  logic [7:0] pal_rd_idx;
`endif

  logic [11:0] rgb;
  assign rgb = {red, green, blue};

  int total  = 0;
  int passed = 0;

  always #10 clk = ~clk;

  jtbubl_colmix dut (
`ifdef JTBUBL_GFX_DEBUG_EN
    .gfx_en     (gfx_en),
    .pal_rd_idx (pal_rd_idx),
`endif
    .clk      (clk),
    .rst      (rst),
    .pxl2_cen (pxl2_cen),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .col_addr (col_addr),
    .pal_cs   (pal_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  typedef struct {
    logic [7:0]  col;
    logic        h;
    logic        v;
    logic [11:0] exp_rgb;
    logic        exp_h;
    logic        exp_v;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
    @(negedge clk);
    pal_cs = 1'b0; cpu_rnw = 1'b1;
  endtask

  task automatic cpu_read_check(input string name, input logic [8:0] a, input logic [7:0] exp);
    @(negedge clk);
    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
    @(posedge clk);
    #1 check(name, {24'd0, pal_dout}, {24'd0, exp});
    @(negedge clk);
    pal_cs = 1'b0;
  endtask

  // One pixel pulse; optionally a CPU write lands on the clk right after it,
  // which is the cycle the sequencer reads the lo byte. Returns two negedges
  // after the pulse edge.
  task automatic pixel(input logic [7:0] c, input logic h, input logic v,
                       input logic wr, input logic [8:0] wa, input logic [7:0] wd);
    @(negedge clk);
    col_addr = c; LHBL = h; LVBL = v; pxl_cen = 1'b1; pxl2_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0; pxl2_cen = 1'b0;
    if (wr) begin
      pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = wa; cpu_dout = wd;
    end
    @(negedge clk);
    pal_cs = 1'b0; cpu_rnw = 1'b1;
  endtask

  task automatic gap();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    // expected outputs follow the previous row's inputs
    vecs[0]  = '{8'hD1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};
    vecs[1]  = '{8'h10, 1'b1, 1'b1, 12'h5CE, 1'b1, 1'b1};
    vecs[2]  = '{8'h42, 1'b1, 1'b1, 12'hA37, 1'b1, 1'b1};
    vecs[3]  = '{8'hD1, 1'b0, 1'b1, 12'h19B, 1'b1, 1'b1};
    vecs[4]  = '{8'hD1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1};
    vecs[5]  = '{8'h42, 1'b1, 1'b0, 12'h5CE, 1'b1, 1'b1};
    vecs[6]  = '{8'h10, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0};
    vecs[7]  = '{8'h00, 1'b1, 1'b1, 12'hA37, 1'b1, 1'b1};
    vecs[8]  = '{8'h00, 1'b0, 1'b0, 12'h123, 1'b1, 1'b1};
    vecs[9]  = '{8'hD1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};
    vecs[10] = '{8'hD1, 1'b1, 1'b1, 12'h5CE, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_rgb",   {20'd0, rgb}, 32'h000);
    check("reset_lhbl",  {31'd0, LHBL_dly}, 32'd0);
    check("reset_lvbl",  {31'd0, LVBL_dly}, 32'd0);
    check("reset_pdout", {24'd0, pal_dout}, 32'd0);
    rst = 1'b0;

    cpu_write(9'h1A2, 8'h5C); cpu_write(9'h1A3, 8'hE0);
    cpu_write(9'h020, 8'hA3); cpu_write(9'h021, 8'h7F);
    cpu_write(9'h084, 8'h19); cpu_write(9'h085, 8'hB4);
    cpu_write(9'h000, 8'h12); cpu_write(9'h001, 8'h30);
    cpu_write(9'h0FF, 8'h3B);

    cpu_read_check("rd_0ff", 9'h0FF, 8'h3B);
    cpu_read_check("rd_1a3", 9'h1A3, 8'hE0);
    cpu_read_check("rd_085", 9'h085, 8'hB4);

    for (int i = 0; i < 11; i++) begin
      pixel(vecs[i].col, vecs[i].h, vecs[i].v, 1'b0, 9'd0, 8'd0);
      check($sformatf("v%0d_rgb", i), {20'd0, rgb}, {20'd0, vecs[i].exp_rgb});
      check($sformatf("v%0d_lhbl", i), {31'd0, LHBL_dly}, {31'd0, vecs[i].exp_h});
      check($sformatf("v%0d_lvbl", i), {31'd0, LVBL_dly}, {31'd0, vecs[i].exp_v});
      gap();
      check($sformatf("v%0d_hold", i), {20'd0, rgb}, {20'd0, vecs[i].exp_rgb});
    end

    // collision: CPU overwrites entry 0 lo byte while the video port reads it
    pixel(8'h00, 1'b1, 1'b1, 1'b1, 9'h000, 8'hFF);
    check("coll_prev", {20'd0, rgb}, 32'h5CE);
    gap();
    pixel(8'h00, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0);
    check("coll_old", {20'd0, rgb}, 32'h123);
    gap();
    pixel(8'h00, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0);
    check("coll_new", {20'd0, rgb}, 32'hFF3);
    gap();

    // reset while the sequencer is in RD_HI
    pixel(8'h42, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0);
    check("pre_rst_rgb", {20'd0, rgb}, 32'hFF3);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rgb",   {20'd0, rgb}, 32'h000);
    check("rst_async_lhbl",  {31'd0, LHBL_dly}, 32'd0);
    check("rst_async_lvbl",  {31'd0, LVBL_dly}, 32'd0);
    check("rst_async_pdout", {24'd0, pal_dout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pixel(8'hD1, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0);
    check("post_rst_1", {20'd0, rgb}, 32'h000);
    gap();
    pixel(8'h10, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0);
    check("post_rst_2", {20'd0, rgb}, 32'h5CE);
    check("post_rst_2h", {31'd0, LHBL_dly}, 32'd1);
    gap();

`ifdef JTBUBL_GFX_DEBUG_EN
    cpu_write(9'h1FE, 8'h0F); cpu_write(9'h1FF, 8'h70);
    gfx_en = 1'b0;
    pixel(8'h10, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0);
    check("dbg_idx", {24'd0, pal_rd_idx}, 32'hFF);
    gap();
    pixel(8'h10, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0);
    check("dbg_rgb", {20'd0, rgb}, 32'h0F7);
    gap();
    gfx_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
